// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
//
// Shared definitions for the sequential multiplier / divider:
//   - state_t   : controller states (IDLE, MUL, DIV, DONE)
//   - OP_MUL / OP_DIV : encoding of the div_mult operation select
//   - MUL_STEPS / DIV_STEPS : iteration counts of each algorithm
//   - CNT_W     : width of the step counter
//   - is_last_step() : true when the counter sits on the final iteration
// -----------------------------------------------------------------------------
package mult_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b1;
    localparam logic OP_DIV = 1'b0;

    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] MUL_STEPS = 6'd16;
    localparam logic [CNT_W-1:0] DIV_STEPS = 6'd32;

    // The counter is cleared on the go sample and advances once per step,
    // so the final iteration is the one where it reads steps-1.
    function automatic logic is_last_step(input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] steps);
        return (cnt == (steps - 6'd1));
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// -----------------------------------------------------------------------------
// mult_div_datapath
//
// Register file and arithmetic for the sequential multiplier / divider.
// One 17-bit add/subtract unit is shared by both algorithms:
//   multiply : shift-add, LSB first. work_reg starts as {16'h0, multiplier};
//              each step conditionally adds the multiplicand into the upper
//              half and shifts the whole 33-bit {carry, work} right by one.
//   divide   : restoring division, MSB first. work_reg starts as the
//              dividend and fills with quotient bits from the right; rem_reg
//              is the 17-bit partial remainder.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   load              latch operands for operation 'op'
//   step              perform one iteration of operation 'op'
//   op                OP_MUL / OP_DIV (selects datapath behaviour)
//   finish            capture the result of the current step into sal_32
//   ent_32, ent_16    operand inputs (used on load only)
//   sal_32            registered result, changes only on finish or reset
// -----------------------------------------------------------------------------
module mult_div_datapath
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        op,
    input  logic        finish,
    input  logic [31:0] ent_32,
    input  logic [15:0] ent_16,
    output logic [31:0] sal_32
);

    logic [31:0] work_reg;      // multiply: {accum_hi, multiplier/accum_lo}; divide: dividend/quotient
    logic [15:0] opnd_reg;      // multiplicand (mul) or divisor (div)
    logic [16:0] rem_reg;       // partial remainder (divide only)
    logic [31:0] sal_reg;

    logic [31:0] work_next;
    logic [16:0] rem_next;

    // Shared add/subtract unit
    logic [16:0] au_a;
    logic [16:0] au_b;
    logic        au_sub;
    logic [17:0] au_res;

    logic [16:0] mul_hi;        // upper 17 bits after the conditional add
    logic        trial_ok;      // divide: trial subtraction did not borrow

    always_comb begin
        au_a   = 17'd0;
        au_b   = {1'b0, opnd_reg};
        au_sub = 1'b0;
        if (op == OP_MUL) begin
            au_a   = {1'b0, work_reg[31:16]};
            au_sub = 1'b0;
        end else begin
            // Trial dividend: remainder shifted left, next dividend bit in.
            au_a   = {rem_reg[15:0], work_reg[31]};
            au_sub = 1'b1;
        end
    end

    // Bit 17 of the difference is the borrow: set exactly when au_a < au_b.
    assign au_res = au_sub ? ({1'b0, au_a} - {1'b0, au_b})
                           : ({1'b0, au_a} + {1'b0, au_b});

    assign trial_ok = ~au_res[17];

    always_comb begin
        mul_hi    = 17'd0;
        work_next = work_reg;
        rem_next  = rem_reg;
        if (op == OP_MUL) begin
            // Current multiplier bit is work_reg[0]; the add's carry lands in
            // bit 31 after the right shift, so nothing is lost.
            mul_hi    = work_reg[0] ? au_res[16:0] : {1'b0, work_reg[31:16]};
            work_next = {mul_hi, work_reg[15:1]};
        end else begin
            // Restore by simply keeping the trial value when it borrowed.
            // With a zero divisor every trial succeeds -> all-ones quotient.
            rem_next  = trial_ok ? au_res[16:0] : au_a;
            work_next = {work_reg[30:0], trial_ok};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_reg <= 32'd0;
            opnd_reg <= 16'd0;
            rem_reg  <= 17'd0;
        end else if (load) begin
            if (op == OP_MUL) begin
                work_reg <= {16'd0, ent_16};
                opnd_reg <= ent_32[15:0];
            end else begin
                work_reg <= ent_32;
                opnd_reg <= ent_16;
            end
            rem_reg <= 17'd0;
        end else if (step) begin
            work_reg <= work_next;
            rem_reg  <= rem_next;
        end
    end

    // The result is taken from the final step's combinational value so it is
    // visible on the same edge the controller raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sal_reg <= 32'd0;
        end else if (finish) begin
            sal_reg <= work_next;
        end
    end

    assign sal_32 = sal_reg;

endmodule

// File: rtl/mult_div_seq.sv
// -----------------------------------------------------------------------------
// mult_div_seq
//
// Sequential 16x16 unsigned multiplier and 32/16 unsigned divider with a
// four-phase go/done handshake. Operands and the operation are latched on the
// edge that samples go=1 in IDLE; a multiply completes 16 edges later, a
// divide 32 edges later. done stays high until go is seen low.
//
// Ports:
//   clk       system clock (posedge)
//   reset     asynchronous active-high reset
//   ent_32    dividend / multiplicand (low 16 bits for multiply)
//   ent_16    divisor / multiplier
//   go        request (level, four-phase)
//   div_mult  1 = multiply, 0 = divide
//   sal_32    product or quotient, held while done=1 and after
//   done      result valid / acknowledge
// -----------------------------------------------------------------------------
module mult_div_seq
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ent_32,
    input  logic [15:0] ent_16,
    input  logic        go,
    input  logic        div_mult,
    output logic [31:0] sal_32,
    output logic        done
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic             op_reg,    op_next;
    logic             done_reg,  done_next;

    logic dp_load;
    logic dp_step;
    logic dp_finish;
    logic dp_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_DIV;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        done_next  = done_reg;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        dp_finish  = 1'b0;
        // While loading, the datapath must follow the incoming select;
        // afterwards it follows the latched one so div_mult can change freely.
        dp_op      = op_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (go) begin
                    dp_load    = 1'b1;
                    dp_op      = div_mult;
                    op_next    = div_mult;
                    cnt_next   = '0;
                    state_next = (div_mult == OP_MUL) ? ST_MUL : ST_DIV;
                end
            end

            ST_MUL: begin
                dp_step  = 1'b1;
                cnt_next = cnt_reg + 6'd1;
                if (is_last_step(cnt_reg, MUL_STEPS)) begin
                    dp_finish  = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DIV: begin
                dp_step  = 1'b1;
                cnt_next = cnt_reg + 6'd1;
                if (is_last_step(cnt_reg, DIV_STEPS)) begin
                    dp_finish  = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!go) begin
                    done_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                done_next  = 1'b0;
            end
        endcase
    end

    mult_div_datapath u_datapath (
        .clk    (clk),
        .rst    (reset),
        .load   (dp_load),
        .step   (dp_step),
        .op     (dp_op),
        .finish (dp_finish),
        .ent_32 (ent_32),
        .ent_16 (ent_16),
        .sal_32 (sal_32)
    );

    assign done = done_reg;

endmodule
